mmio_fifo_ctrl: RTL and testbench
=================================

# mmio_fifo_ctrl

MMIO-facing controller for the AFU's 64-bit data FIFO. Decodes host MMIO writes and reads into push and pop operations, owns the pointers, occupancy count and sticky error flags, and returns registered read responses with the host TID. Sits between the CCI-P MMIO decode in the AFU top and the FIFO storage; the AFU top muxes its response with the DFH/AFU_ID responses.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..128
- ADDR_DATA, 16'h0020, push on write, pop on read
- ADDR_STATUS, 16'h0022, read-only status word
- ADDR_CTRL, 16'h0024, write-only control word

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- mmio_wr_valid  in  1  MMIO write strobe, single cycle
- mmio_rd_valid  in  1  MMIO read strobe, single cycle
- mmio_addr  in  16  MMIO address (dword units, as in CCI-P header)
- mmio_tid  in  9  read transaction ID
- mmio_wdata  in  64  write data
- rsp_valid  out  1  read response valid, one-cycle pulse
- rsp_tid  out  9  TID echoed from the request
- rsp_data  out  64  response data
- count  out  $clog2(DEPTH+1)  current occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- irq  out  1  overflow | underflow sticky flags

## Operation
- Write ADDR_DATA: not full -> mem[wr_ptr] <= wdata, wr_ptr++, count++. Full -> data dropped, overflow flag set.
- Read ADDR_DATA: not empty -> rsp_data = mem[rd_ptr], rd_ptr++, count--. Empty -> rsp_data = 0, underflow flag set.
- Read ADDR_STATUS: rsp_data = {46'b0, underflow[17], overflow[16], 6'b0, full[9], empty[8], count zero-extended to [7:0]}.
- Write ADDR_CTRL: bit0 flush (wr_ptr, rd_ptr, count <= 0; storage untouched); bit1 clear both sticky flags; other bits ignored.
- Read of ADDR_CTRL: rsp_data = 0. Reads of any other address: no response (rsp_valid stays 0). Writes to other addresses: ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty derive from count only.
- Simultaneous mmio_wr_valid and mmio_rd_valid: both processed; each evaluated against pre-cycle state. Push and pop both succeeding -> count unchanged. Read from empty + push -> underflow, returns 0, pushed word retained.
- Flush write with same-cycle ADDR_DATA read: read pops and returns pre-flush head; flush wins on pointers/count.
- Clear write with same-cycle underflow: set wins.

## Timing
- Reset: rsp_valid 0, rsp_tid 0, rsp_data 0, count 0, empty 1, full 0, irq 0, pointers 0, flags 0.
- Read latency: request in cycle N -> rsp_valid, rsp_tid, rsp_data registered, valid in cycle N+1 only.
- Write effects (count, full, empty, flags, irq) visible cycle N+1.
- Back-to-back reads every cycle supported; each gets its own response.
- Reset asserted mid-operation: all state clears immediately; no response issued for an in-flight request.

## Structure
- mmio_fifo_pkg: ADDR_* defaults, status bit positions (STS_EMPTY=8, STS_FULL=9, STS_OVF=16, STS_UNF=17), CTRL_FLUSH=0, CTRL_CLR=1.
- Sub-module fifo_ram: DEPTH x 64 array, synchronous write port, combinational read at rd_ptr; no reset on the array.
- Controller holds decode, pointers, count, flags and response register.

## Test plan
- Reset then read ADDR_STATUS -> rsp_data = 64'h100 one cycle later, TID echoed.
- Push 0x11, 0x22, 0x33 then three ADDR_DATA reads -> 0x11, 0x22, 0x33 in order; final status 0x100.
- Fill 8 entries, push 0xDEAD -> dropped, status 0x10208, irq=1; drain 8 reads return original order; write CTRL=2 -> irq=0.
- Read ADDR_DATA when empty -> rsp_data 0, underflow bit 17 set; simultaneous read+push of 0x55 on empty -> returns 0, count=1, next read 0x55.
- Push 12 / pop 12 interleaved across wrap with DEPTH=8 -> FIFO order preserved, count never exceeds 8.
- Push 4, write CTRL=1 -> count 0, empty 1; read to 16'h0030 -> no rsp_valid; assert rst_n low mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/mmio_fifo_pkg.sv
// Shared constants for the MMIO-mapped 64-bit data FIFO: default register
// addresses, status/control bit positions and the status word packer.
package mmio_fifo_pkg;

    localparam logic [15:0] DFLT_ADDR_DATA   = 16'h0020;
    localparam logic [15:0] DFLT_ADDR_STATUS = 16'h0022;
    localparam logic [15:0] DFLT_ADDR_CTRL   = 16'h0024;

    localparam int STS_EMPTY = 8;
    localparam int STS_FULL  = 9;
    localparam int STS_OVF   = 16;
    localparam int STS_UNF   = 17;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_CLR   = 1;

    function automatic logic [63:0] status_word(
        input logic [7:0] cnt,
        input logic       emp,
        input logic       ful,
        input logic       ovf,
        input logic       unf
    );
        logic [63:0] w;
        w            = '0;
        w[7:0]       = cnt;
        w[STS_EMPTY] = emp;
        w[STS_FULL]  = ful;
        w[STS_OVF]   = ovf;
        w[STS_UNF]   = unf;
        return w;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: DEPTH x W array, synchronous write, combinational read.
// The array is deliberately not reset; occupancy tracking lives in the controller.
module fifo_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO front end for the AFU data FIFO: decodes writes/reads into push/pop,
// tracks pointers, occupancy and sticky error flags, returns registered responses.
module mmio_fifo_ctrl
    import mmio_fifo_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter logic [15:0] ADDR_DATA   = DFLT_ADDR_DATA,
    parameter logic [15:0] ADDR_STATUS = DFLT_ADDR_STATUS,
    parameter logic [15:0] ADDR_CTRL   = DFLT_ADDR_CTRL
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mmio_wr_valid,
    input  logic                       mmio_rd_valid,
    input  logic [15:0]                mmio_addr,
    input  logic [8:0]                 mmio_tid,
    input  logic [63:0]                mmio_wdata,
    output logic                       rsp_valid,
    output logic [8:0]                 rsp_tid,
    output logic [63:0]                rsp_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Strobes are single-cycle with no back-pressure: every mmio_rd_valid to a
    // mapped address yields exactly one rsp_valid pulse on the following cycle.
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          ovf_q, unf_q;
    logic [63:0]   ram_rdata;

    logic wr_data_hit, rd_data_hit, wr_ctrl_hit;
    logic do_push, do_pop, do_flush, do_clr, ovf_set, unf_set;
    logic          rd_known;
    logic [63:0]   rd_word;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign irq   = ovf_q | unf_q;

    assign wr_data_hit = mmio_wr_valid && (mmio_addr == ADDR_DATA);
    assign rd_data_hit = mmio_rd_valid && (mmio_addr == ADDR_DATA);
    assign wr_ctrl_hit = mmio_wr_valid && (mmio_addr == ADDR_CTRL);

    // Both directions are judged against pre-cycle occupancy.
    assign do_push  = wr_data_hit && !full;
    assign ovf_set  = wr_data_hit && full;
    assign do_pop   = rd_data_hit && !empty;
    assign unf_set  = rd_data_hit && empty;
    assign do_flush = wr_ctrl_hit && mmio_wdata[CTRL_FLUSH];
    assign do_clr   = wr_ctrl_hit && mmio_wdata[CTRL_CLR];

    always_comb begin
        rd_known = 1'b0;
        rd_word  = '0;
        if (mmio_rd_valid) begin
            if (mmio_addr == ADDR_DATA) begin
                rd_known = 1'b1;
                rd_word  = empty ? 64'd0 : ram_rdata;
            end else if (mmio_addr == ADDR_STATUS) begin
                rd_known = 1'b1;
                rd_word  = status_word(8'(count_q), empty, full, ovf_q, unf_q);
            end else if (mmio_addr == ADDR_CTRL) begin
                rd_known = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            if (do_flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
                count_q <= count_q + CW'(do_push) - CW'(do_pop);
            end
            // A same-cycle set beats a clear.
            ovf_q <= (ovf_q & ~do_clr) | ovf_set;
            unf_q <= (unf_q & ~do_clr) | unf_set;

            rsp_valid <= rd_known;
            if (rd_known) begin
                rsp_tid  <= mmio_tid;
                rsp_data <= rd_word;
            end
        end
    end

    fifo_ram #(.DEPTH(DEPTH), .W(64)) u_ram (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (mmio_wdata),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Bench for mmio_fifo_ctrl: drives MMIO strobes, keeps a queue model of the
// FIFO and flags, and scores registered responses against an expected queue.
module tb_mmio_fifo_ctrl;

    localparam int          DEPTH  = 8;
    localparam logic [15:0] A_DATA = 16'h0020;
    localparam logic [15:0] A_STS  = 16'h0022;
    localparam logic [15:0] A_CTRL = 16'h0024;
    localparam logic [15:0] A_BAD  = 16'h0030;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mmio_wr_valid = 1'b0;
    logic        mmio_rd_valid = 1'b0;
    logic [15:0] mmio_addr = '0;
    logic [8:0]  mmio_tid = '0;
    logic [63:0] mmio_wdata = '0;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic [3:0]  count;
    logic        empty, full, irq;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [63:0] exp_q[$];
    logic [8:0]  tid_q[$];
    logic [63:0] mq[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic        mon_en = 1'b0;

    mmio_fifo_ctrl #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_addr     (mmio_addr),
        .mmio_tid      (mmio_tid),
        .mmio_wdata    (mmio_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_tid       (rsp_tid),
        .rsp_data      (rsp_data),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_status();
        logic [63:0] w;
        w        = '0;
        w[7:0]   = 8'(mq.size());
        w[8]     = (mq.size() == 0);
        w[9]     = (mq.size() == DEPTH);
        w[16]    = m_ovf;
        w[17]    = m_unf;
        return w;
    endfunction

    // Scoreboard: every response pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (mon_en && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexp_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                check_val("rsp_data", rsp_data, exp_q.pop_front());
                check_val("rsp_tid", 64'(rsp_tid), 64'(tid_q.pop_front()));
            end
        end
    end

    task automatic check_outputs(input string tag);
        check_val({tag, "_count"}, 64'(count), 64'(mq.size()));
        check_val({tag, "_empty"}, 64'(empty), 64'(mq.size() == 0));
        check_val({tag, "_full"},  64'(full),  64'(mq.size() == DEPTH));
        check_val({tag, "_irq"},   64'(irq),   64'(m_ovf | m_unf));
    endtask

    // One bus cycle: strobes applied at posedge+1, model updated against pre-cycle state.
    task automatic drive(input logic wr, input logic rd, input logic [15:0] addr,
                         input logic [63:0] wd, input logic [8:0] tid, input bit chk);
        int  pre_size;
        bit  push_ok;
        pre_size      = mq.size();
        mmio_wr_valid = wr;
        mmio_rd_valid = rd;
        mmio_addr     = addr;
        mmio_wdata    = wd;
        mmio_tid      = tid;
        push_ok       = wr && (addr == A_DATA) && (pre_size < DEPTH);
        if (rd) begin
            if (addr == A_DATA) begin
                if (pre_size > 0) exp_q.push_back(mq.pop_front());
                else begin
                    exp_q.push_back(64'd0);
                    m_unf = 1'b1;
                end
                tid_q.push_back(tid);
            end else if (addr == A_STS) begin
                exp_q.push_back(model_status());
                tid_q.push_back(tid);
            end else if (addr == A_CTRL) begin
                exp_q.push_back(64'd0);
                tid_q.push_back(tid);
            end
        end
        if (wr && addr == A_DATA) begin
            if (push_ok) mq.push_back(wd);
            else m_ovf = 1'b1;
        end
        if (wr && addr == A_CTRL) begin
            if (wd[1]) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (wd[0]) mq.delete();
        end
        @(posedge clk);
        #1;
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        if (chk) check_outputs("op");
    endtask

    task automatic push(input logic [63:0] d);
        drive(1'b1, 1'b0, A_DATA, d, 9'd0, 1'b1);
    endtask

    task automatic rd(input logic [15:0] a, input logic [8:0] t);
        drive(1'b0, 1'b1, a, 64'd0, t, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_val({tag, "_rsp_tid"},   64'(rsp_tid),   64'd0);
        check_val({tag, "_rsp_data"},  rsp_data,       64'd0);
        check_val({tag, "_count"},     64'(count),     64'd0);
        check_val({tag, "_empty"},     64'(empty),     64'd1);
        check_val({tag, "_full"},      64'(full),      64'd0);
        check_val({tag, "_irq"},       64'(irq),       64'd0);
    endtask

    initial begin
        int pushes;
        int pops;
        bit do_p;

        // Reset
        idle(2);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        idle(1);
        mon_en = 1'b1;

        // Status after reset
        rd(A_STS, 9'h1A5);
        idle(1);
        check_val("sts_reset_model", model_status(), 64'h100);

        // Simple order
        push(64'h11);
        push(64'h22);
        push(64'h33);
        rd(A_DATA, 9'd1);
        rd(A_DATA, 9'd2);
        rd(A_DATA, 9'd3);
        rd(A_STS, 9'd4);

        // Fill, overflow, drain, clear
        for (int i = 0; i < DEPTH; i++) push({32'hA000_0000, 32'($urandom_range(0, 65535))});
        push(64'hDEAD);
        rd(A_STS, 9'd5);
        for (int i = 0; i < DEPTH; i++) rd(A_DATA, 9'(10 + i));
        drive(1'b1, 1'b0, A_CTRL, 64'd2, 9'd0, 1'b1);

        // Underflow, then simultaneous read+push on empty
        rd(A_DATA, 9'd20);
        rd(A_STS, 9'd21);
        drive(1'b1, 1'b1, A_DATA, 64'h55, 9'd22, 1'b1);
        rd(A_DATA, 9'd23);
        drive(1'b1, 1'b0, A_CTRL, 64'd2, 9'd0, 1'b1);

        // Interleaved traffic across pointer wrap
        pushes = 0;
        pops   = 0;
        push(64'h1);
        push(64'h2);
        push(64'h3);
        push(64'h4);
        push(64'h5);
        pushes = 5;
        while (pushes < 12 || pops < 12) begin
            if (pushes >= 12) do_p = 1'b0;
            else if (mq.size() == 0) do_p = 1'b1;
            else if (mq.size() == DEPTH || pops >= pushes) do_p = 1'b0;
            else do_p = ($urandom_range(0, 1) == 1);
            if (do_p) begin
                push(64'($urandom_range(1, 32'hFFFF)) | 64'hC0DE_0000_0000);
                pushes++;
            end else begin
                rd(A_DATA, 9'($urandom_range(0, 511)));
                pops++;
            end
        end

        // Flush, ctrl read, unmapped read, back-to-back reads
        for (int i = 0; i < 4; i++) push(64'h700 + 64'(i));
        drive(1'b1, 1'b0, A_CTRL, 64'd1, 9'd0, 1'b1);
        rd(A_CTRL, 9'd30);
        rd(A_BAD, 9'd31);
        push(64'h901);
        push(64'h902);
        rd(A_STS, 9'd32);
        rd(A_DATA, 9'd33);
        rd(A_STS, 9'd34);
        idle(2);

        // Reset asserted with a read strobe in flight
        push(64'hBEEF);
        mmio_rd_valid = 1'b1;
        mmio_addr     = A_DATA;
        mmio_tid      = 9'h1FF;
        #2;
        rst_n = 1'b0;
        mmio_rd_valid = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        idle(2);
        check_reset_outputs("mid_rst");
        rst_n = 1'b1;
        idle(1);
        rd(A_STS, 9'd40);
        idle(3);

        check_val("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
